// File: rtl/audio_pkg.sv
// Shared types and default constants for the audio sample path and its I2S output stage.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_t;

  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_WIDTH     = 24;
  localparam int SAMPLE_RATE   = 48000;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Stereo sample handshake between the sample-generation path and the I2S transmitter.
interface i2s_transmitter_if import audio_pkg::*; #(
  parameter int WIDTH = I2S_WIDTH
) ();

  // valid/ready: the source holds sample_l/sample_r stable while valid is high; one
  // frame transfers on each clk edge where valid && ready; ready never depends on valid.
  logic [WIDTH-1:0] sample_l;
  logic [WIDTH-1:0] sample_r;
  logic             valid;
  logic             ready;

  modport master (output sample_l, output sample_r, output valid, input ready);
  modport slave  (input sample_l, input sample_r, input valid, output ready);

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clks while run is high and strobes
// bclk_fall in the clk cycle whose edge takes bclk from 1 to 0.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic bclk,
  output logic bclk_fall
);

  localparam int            CW       = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          div_wrap;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign bclk_fall = run && div_wrap && bclk;

  // Dropping run parks the divider so the next start begins a fresh low half-period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Single-frame-buffered stereo I2S transmitter: accepts frames over a valid/ready
// handshake and serialises them MSB-first with the standard one-bit word-select delay.
module i2s_transmitter import audio_pkg::*; #(
  parameter int WIDTH     = I2S_WIDTH,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int BCLK_DIV  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  i2s_transmitter_if.slave   smp,
  output logic               bclk,
  output logic               lrclk,
  output logic               sdata,
  output logic               underrun,
  output i2s_state_t         state_dbg
);

  localparam int            FRAME_BITS = 2 * SLOT_BITS;
  localparam int            BW         = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  i2s_state_t       state, state_next;
  logic             load, run, bclk_fall, frame_wrap, accept;
  logic             ready_q;
  logic [WIDTH-1:0] hold_l, hold_r, word_l, word_r, next_l, next_r;
  logic [BW-1:0]    bit_cnt, bit_next;

  // Serial bit for frame position b: left slot first, MSB first, zero padding after WIDTH.
  function automatic logic frame_bit(input logic [WIDTH-1:0] wl, input logic [WIDTH-1:0] wr,
                                     input logic [BW-1:0] b);
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] sh;
    int               p;
    w  = (int'(b) < SLOT_BITS) ? wl : wr;
    p  = int'(b) % SLOT_BITS;
    sh = '0;
    if (p < WIDTH) sh = w >> (WIDTH - 1 - p);
    return sh[0];
  endfunction

  // Word select leads the data by one bit.
  function automatic logic lr_of(input logic [BW-1:0] b);
    return ((int'(b) + 1) % FRAME_BITS) >= SLOT_BITS;
  endfunction

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk       (clk),
    .rstn      (rstn),
    .run       (run),
    .bclk      (bclk),
    .bclk_fall (bclk_fall)
  );

  assign frame_wrap = bclk_fall && (bit_cnt == BIT_LAST);
  assign bit_next   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN:   if (enable) state_next = RUN;
               else if (frame_wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    run  = 1'b0;
    case (state)
      IDLE:  load = enable;
      RUN:   begin run = 1'b1; load = frame_wrap; end
      DRAIN: begin run = 1'b1; load = frame_wrap && enable; end
      default: ;
    endcase
  end

  // A write landing in a load cycle is not visible to that load; it waits for the next frame.
  assign accept    = smp.valid && ready_q;
  assign smp.ready = ready_q;
  assign next_l    = ready_q ? '0 : hold_l;
  assign next_r    = ready_q ? '0 : hold_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q <= 1'b1;
      hold_l  <= '0;
      hold_r  <= '0;
    end else if (accept) begin
      ready_q <= 1'b0;
      hold_l  <= smp.sample_l;
      hold_r  <= smp.sample_r;
    end else if (load) begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_l   <= '0;
      word_r   <= '0;
      bit_cnt  <= '0;
      sdata    <= 1'b0;
      lrclk    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= load && ready_q;
      if (load) begin
        word_l  <= next_l;
        word_r  <= next_r;
        bit_cnt <= '0;
        sdata   <= frame_bit(next_l, next_r, BW'(0));
        lrclk   <= lr_of(BW'(0));
      end else if (state_next == IDLE) begin
        bit_cnt <= '0;
        sdata   <= 1'b0;
        lrclk   <= 1'b0;
      end else if (bclk_fall) begin
        bit_cnt <= bit_next;
        sdata   <= frame_bit(word_l, word_r, bit_next);
        lrclk   <= lr_of(bit_next);
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed-sequence bench for i2s_transmitter: random frames, a frame-level reference
// model of the holding register, and per-clk checks of bclk/lrclk/sdata/underrun/ready.
module tb_i2s_transmitter;
  import audio_pkg::*;

  localparam int W   = 24;
  localparam int S   = 32;
  localparam int DIV = 2;
  localparam int CPB = 2 * DIV;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       bclk, lrclk, sdata, underrun;
  i2s_state_t state_dbg;

  i2s_transmitter_if #(.WIDTH(W)) smp ();

  i2s_transmitter #(.WIDTH(W), .SLOT_BITS(S), .BCLK_DIV(DIV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .smp       (smp),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .underrun  (underrun),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frames waiting to be offered, frames accepted but not yet on the wire, frame on the wire.
  logic [2*W-1:0] pend_q[$];
  logic [2*W-1:0] exp_q[$];
  bit             m_full;
  logic [W-1:0]   cur_l, cur_r;
  bit             cur_und;

  task automatic chk(input string tag, input int b, input int k,
                     input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s (bit %0d clk %0d): observed %0h expected %0h", tag, b, k, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] rand_frame();
    return {W'($urandom), W'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    logic [2*W-1:0] f;
    if (pend_q.size() > 0) begin
      f            = pend_q[0];
      smp.valid    = 1'b1;
      smp.sample_l = f[2*W-1:W];
      smp.sample_r = f[W-1:0];
    end else begin
      smp.valid    = 1'b0;
      smp.sample_l = W'($urandom);
      smp.sample_r = W'($urandom);
    end
  endtask

  // Advance one clk and apply the holding-register rules to the model.
  task automatic step(input bit ld);
    bit             acc;
    logic [2*W-1:0] din;
    acc = smp.valid && !m_full;
    din = {smp.sample_l, smp.sample_r};
    tick();
    if (ld) begin
      cur_und = !m_full;
      if (m_full) {cur_l, cur_r} = exp_q.pop_front();
      else        {cur_l, cur_r} = '0;
      m_full = 1'b0;
    end
    if (acc) begin
      exp_q.push_back(din);
      m_full = 1'b1;
      void'(pend_q.pop_front());
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      chk("idle_bclk", -1, i, bclk, 1'b0);
      chk("idle_lrclk", -1, i, lrclk, 1'b0);
      chk("idle_sdata", -1, i, sdata, 1'b0);
      chk("idle_underrun", -1, i, underrun, 1'b0);
      chk("idle_ready", -1, i, smp.ready, !m_full);
      chk("idle_state", -1, i, state_dbg, IDLE);
      step(1'b0);
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    drive_inputs();
    step(1'b1);
  endtask

  // Walks one whole frame starting in the first clk after its load.
  task automatic send_frame(input int drop_at, input int raise_at, input bit push_last);
    logic [2*S-1:0] fv;
    bit             ld;
    fv = '0;
    fv[2*S-1 -: W] = cur_l;
    fv[S-1 -: W]   = cur_r;
    for (int b = 0; b < 2*S; b++) begin
      for (int k = 0; k < CPB; k++) begin
        if (k == 0 && b == drop_at)  enable = 1'b0;
        if (k == 0 && b == raise_at) enable = 1'b1;
        if (push_last && b == 2*S-1 && k == CPB-1) pend_q.push_back(rand_frame());
        drive_inputs();
        chk("bclk", b, k, bclk, (k >= DIV));
        chk("lrclk", b, k, lrclk, (b >= S-1 && b <= 2*S-2));
        chk("sdata", b, k, sdata, fv[2*S-1-b]);
        chk("underrun", b, k, underrun, (b == 0 && k == 0) ? cur_und : 1'b0);
        chk("ready", b, k, smp.ready, !m_full);
        ld = (b == 2*S-1 && k == CPB-1) && enable;
        step(ld);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rstn = 1'b1; enable = 1'b0;
    smp.valid = 1'b0; smp.sample_l = '0; smp.sample_r = '0;
    m_full = 1'b0; cur_l = '0; cur_r = '0; cur_und = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_bclk", -1, 0, bclk, 1'b0);
    chk("rst_lrclk", -1, 0, lrclk, 1'b0);
    chk("rst_sdata", -1, 0, sdata, 1'b0);
    chk("rst_underrun", -1, 0, underrun, 1'b0);
    chk("rst_ready", -1, 0, smp.ready, 1'b1);
    chk("rst_state", -1, 0, state_dbg, IDLE);
    repeat (2) tick();
    rstn = 1'b1;
    check_idle(4);

    // Single directed frame, then underrun frames while enable stays high.
    pend_q.push_back({24'h800001, 24'h7FFFFF});
    check_idle(3);
    start_run();
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    send_frame(-1, -1, 1'b0);
    send_frame(0, -1, 1'b0);
    check_idle(4);

    // Back-to-back with valid held high; last frame drains with the next one still held.
    pend_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    pend_q.push_back({24'h111111, 24'h222222});
    pend_q.push_back({24'h333333, 24'h444444});
    repeat (4) pend_q.push_back(rand_frame());
    check_idle(2);
    start_run();
    repeat (5) send_frame(-1, -1, 1'b0);
    send_frame(10, -1, 1'b0);
    check_idle(6);

    // Restart, drain at b=10 then re-enable at b=40, then a write landing on the wrap cycle.
    pend_q.push_back(rand_frame());
    start_run();
    send_frame(10, 40, 1'b0);
    send_frame(-1, -1, 1'b1);
    send_frame(-1, -1, 1'b0);
    send_frame(5, -1, 1'b0);
    check_idle(4);

    // Asynchronous reset in the middle of a frame at a random clk phase.
    pend_q.push_back(rand_frame());
    check_idle(1);
    start_run();
    repeat ($urandom_range(3, 200)) begin
      drive_inputs();
      step(1'b0);
    end
    #($urandom_range(0, 3));
    rstn = 1'b0;
    #1;
    chk("midrst_bclk", -1, 0, bclk, 1'b0);
    chk("midrst_lrclk", -1, 0, lrclk, 1'b0);
    chk("midrst_sdata", -1, 0, sdata, 1'b0);
    chk("midrst_underrun", -1, 0, underrun, 1'b0);
    chk("midrst_ready", -1, 0, smp.ready, 1'b1);
    chk("midrst_state", -1, 0, state_dbg, IDLE);
    enable = 1'b0;
    smp.valid = 1'b0;
    tick();
    rstn = 1'b1;
    m_full = 1'b0;
    exp_q.delete();
    pend_q.delete();
    check_idle(3);

    // Normal operation resumes after reset.
    pend_q.push_back(rand_frame());
    check_idle(1);
    start_run();
    send_frame(20, -1, 1'b0);
    check_idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
